// File: rtl/pc_branch_if.sv
// pc_branch_if: fetch/decode/branch bus between the PC sequencer and its environment
//   start        master->slave  leave IDLE and begin fetching
//   mem_req      slave->master  fetch request, address is pc_out
//   mem_ack      master->slave  instr_in is valid this cycle
//   instr_in     master->slave  fetched instruction word
//   pc_out       slave->master  current PC / fetch address
//   instr_out    slave->master  latched instruction for the decoder
//   instr_valid  slave->master  one-cycle pulse when instr_out updates
//   branch_req   master->slave  current instruction is a PC-relative branch
//   branch_cond  master->slave  branch condition, sampled in BRWAIT
//   halt         master->slave  current instruction is HALT
//   offset_in    master->slave  sign-extended branch offset
//   taken_cnt    slave->master  taken branches since reset
interface pc_branch_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              mem_req;
    logic              mem_ack;
    logic [15:0]       instr_in;
    logic [ADDR_W-1:0] pc_out;
    logic [15:0]       instr_out;
    logic              instr_valid;
    logic              branch_req;
    logic              branch_cond;
    logic              halt;
    logic [15:0]       offset_in;
    logic [CNT_W-1:0]  taken_cnt;

    modport master (
        output start, mem_ack, instr_in, branch_req, branch_cond, halt, offset_in,
        input  mem_req, pc_out, instr_out, instr_valid, taken_cnt
    );

    modport slave (
        input  start, mem_ack, instr_in, branch_req, branch_cond, halt, offset_in,
        output mem_req, pc_out, instr_out, instr_valid, taken_cnt
    );
endinterface

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program-counter / fetch sequencer with PC-relative branches
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   io_bus  pc_branch_if.slave: fetch handshake, decoder feedback, branch offset, counters
module pc_branch_unit #(
    parameter int          ADDR_W   = 16,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_INC   = 1,
    parameter int          CNT_W    = 8
) (
    input logic        clk,
    input logic        rst,
    pc_branch_if.slave io_bus
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_BRWAIT, S_HALT} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_pc_seq;
    logic [ADDR_W-1:0] w_off;
    logic [15:0]       r_instr;
    logic              r_valid;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_taken;
    logic              w_load;

    // offset is two's complement; casting the signed value sign-extends (or truncates) to PC width
    assign w_off    = ADDR_W'($signed(io_bus.offset_in));
    assign w_pc_seq = r_pc + ADDR_W'(PC_INC);
    assign w_load   = (r_state == S_FETCH) && io_bus.mem_ack;

    always_comb begin
        w_next    = r_state;
        w_pc_next = r_pc;
        w_taken   = 1'b0;
        unique case (r_state)
            S_IDLE:   w_next = io_bus.start ? S_FETCH : S_IDLE;
            S_FETCH:  w_next = io_bus.mem_ack ? S_DECODE : S_FETCH;
            S_DECODE: begin
                // halt outranks branch_req; neither moves the PC
                w_next    = io_bus.halt ? S_HALT : (io_bus.branch_req ? S_BRWAIT : S_FETCH);
                w_pc_next = (io_bus.halt || io_bus.branch_req) ? r_pc : w_pc_seq;
            end
            S_BRWAIT: begin
                w_next    = S_FETCH;
                w_taken   = io_bus.branch_cond;
                w_pc_next = io_bus.branch_cond ? w_pc_seq + w_off : w_pc_seq;
            end
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= ADDR_W'(RESET_PC);
            r_instr <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            r_valid <= w_load;
            if (w_load) r_instr <= io_bus.instr_in;
            if (w_taken) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign io_bus.mem_req     = (r_state == S_FETCH);
    assign io_bus.pc_out      = r_pc;
    assign io_bus.instr_out   = r_instr;
    assign io_bus.instr_valid = r_valid;
    assign io_bus.taken_cnt   = r_cnt;
endmodule
